// File: rtl/matrix_det_loader.sv
// Loads a signed 3x3 matrix one element per handshake, then computes its determinant
// with a six-term sequential multiply-accumulate and hands matrix + determinant downstream.
module matrix_det_loader #(
  parameter  int DW   = 16,
  localparam int DETW = 3*DW+3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [9*DW-1:0]        out_matrix,
  output logic signed [DETW-1:0] out_det,
  output logic                   out_singular
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready and out_valid are decoded from the state register alone, so neither
  // depends combinationally on the opposite side's valid/ready.
  typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

  state_t                 state;
  logic [3:0]             idx;
  logic [2:0]             term;
  logic signed [DETW-1:0] acc;
  logic signed [DW-1:0]   m [9];

  logic signed [DW-1:0]   op_a, op_b, op_c;
  logic                   neg;
  logic [2*DW-1:0]        p2;
  logic [3*DW-1:0]        p3;
  logic signed [DETW-1:0] term_ext;
  logic signed [DETW-1:0] sum;

  // Rule-of-Sarrus term selection; terms 3..5 are subtracted.
  always_comb begin
    op_a = m[0];
    op_b = m[4];
    op_c = m[8];
    neg  = 1'b0;
    case (term)
      3'd1: begin op_a = m[1]; op_b = m[5]; op_c = m[6]; end
      3'd2: begin op_a = m[2]; op_b = m[3]; op_c = m[7]; end
      3'd3: begin op_a = m[2]; op_b = m[4]; op_c = m[6]; neg = 1'b1; end
      3'd4: begin op_a = m[0]; op_b = m[5]; op_c = m[7]; neg = 1'b1; end
      3'd5: begin op_a = m[1]; op_b = m[3]; op_c = m[8]; neg = 1'b1; end
      default: ;
    endcase
  end

  // Operands are sign-extended to the full product width first, so the low bits of the
  // unsigned product are the exact two's-complement result with no truncation.
  assign p2       = {{DW{op_a[DW-1]}}, op_a} * {{DW{op_b[DW-1]}}, op_b};
  assign p3       = {{DW{p2[2*DW-1]}}, p2} * {{2*DW{op_c[DW-1]}}, op_c};
  assign term_ext = {{3{p3[3*DW-1]}}, p3};
  assign sum      = neg ? (acc - term_ext) : (acc + term_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      idx          <= '0;
      term         <= '0;
      acc          <= '0;
      out_det      <= '0;
      out_singular <= 1'b0;
      for (int i = 0; i < 9; i++) m[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < 9; i++) begin
              if (idx == 4'(i)) m[i] <= in_data;
            end
            if (idx == 4'd8) begin
              idx   <= '0;
              acc   <= '0;
              term  <= '0;
              state <= CALC;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        CALC: begin
          if (term == 3'd5) begin
            out_det      <= sum;
            out_singular <= (sum == '0);
            state        <= DONE;
          end else begin
            acc  <= sum;
            term <= term + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DONE);

  for (genvar g = 0; g < 9; g++) begin : g_out
    assign out_matrix[g*DW +: DW] = m[g];
  end

endmodule

// File: tb/tb_matrix_det_loader.sv
// Directed bench for matrix_det_loader: hand-computed determinants, latency,
// backpressure, gapped input and reset recovery.
module tb_matrix_det_loader;

  localparam int DW   = 16;
  localparam int DETW = 3*DW+3;
  localparam int MW   = 9*DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [MW-1:0]   out_matrix;
  logic [DETW-1:0] out_det;
  logic            out_singular;

  logic [DETW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  matrix_det_loader #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_matrix(out_matrix), .out_det(out_det), .out_singular(out_singular)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input int e0, input int e1, input int e2,
                                       input int e3, input int e4, input int e5,
                                       input int e6, input int e7, input int e8);
    int e[9];
    logic [MW-1:0] r;
    e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
    r = '0;
    for (int i = 0; i < 9; i++) r[i*DW +: DW] = e[i][DW-1:0];
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic load_matrix(input logic [MW-1:0] mat, input bit gapped);
    for (int i = 0; i < 9; i++) begin
      if (gapped) begin
        in_valid = 1'b0;
        in_data  = 16'd7;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = mat[i*DW +: DW];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_matrix(input string tag, input logic [MW-1:0] mat,
                            input logic [DETW-1:0] exp_det, input bit gapped, input bit hold);
    int lat;
    logic [DETW-1:0] e;
    out_ready = !hold;
    exp_q.push_back(exp_det);
    check({tag, "_ready_before"}, MW'(in_ready), MW'(1));
    load_matrix(mat, gapped);
    check({tag, "_ready_low"}, MW'(in_ready), MW'(0));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, MW'(lat), MW'(6));
    if (out_valid) begin
      e = exp_q.pop_front();
      check({tag, "_det"}, MW'(out_det), MW'(e));
      check({tag, "_singular"}, MW'(out_singular), MW'(e == '0));
      check({tag, "_matrix"}, out_matrix, mat);
    end
    if (!hold) begin
      @(posedge clk); #1;
      check({tag, "_ready_after"}, MW'(in_ready), MW'(1));
      check({tag, "_valid_after"}, MW'(out_valid), MW'(0));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, MW'(in_ready), MW'(1));
    check({tag, "_out_valid"}, MW'(out_valid), MW'(0));
    check({tag, "_out_matrix"}, out_matrix, MW'(0));
    check({tag, "_out_det"}, MW'(out_det), MW'(0));
    check({tag, "_out_singular"}, MW'(out_singular), MW'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [MW-1:0]   ident, m123, ones, d234, dneg;
    logic [DETW-1:0] big_neg;

    ident   = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
    m123    = mk(1, 2, 3, 0, 1, 4, 5, 6, 0);
    ones    = mk(1, 1, 1, 1, 1, 1, 1, 1, 1);
    d234    = mk(2, 0, 0, 0, 3, 0, 0, 0, 4);
    dneg    = mk(-32768, 0, 0, 0, -32768, 0, 0, 0, -32768);
    big_neg = -(51'sd1 <<< 45);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("rst0");

    run_matrix("ident", ident, DETW'(1), 1'b0, 1'b0);
    run_matrix("m123",  m123,  DETW'(1), 1'b0, 1'b0);
    run_matrix("ones",  ones,  DETW'(0), 1'b0, 1'b0);
    run_matrix("d234",  d234,  DETW'(24), 1'b0, 1'b0);
    run_matrix("dneg",  dneg,  big_neg, 1'b0, 1'b0);

    // Backpressure: result held while upstream keeps offering 7s.
    run_matrix("bp", d234, DETW'(24), 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 16'd7;
      @(posedge clk); #1;
      check("bp_valid_held", MW'(out_valid), MW'(1));
      check("bp_ready_low", MW'(in_ready), MW'(0));
      check("bp_det_held", MW'(out_det), MW'(24));
      check("bp_matrix_held", out_matrix, d234);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_release_ready", MW'(in_ready), MW'(1));
    check("bp_release_valid", MW'(out_valid), MW'(0));
    run_matrix("bp_next", ident, DETW'(1), 1'b0, 1'b0);

    run_matrix("gap", d234, DETW'(24), 1'b1, 1'b0);

    // Reset after four accepted elements.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = m123[i*DW +: DW];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    pulse_reset();
    check_reset_state("rst_partial");
    run_matrix("rst_partial_ident", ident, DETW'(1), 1'b0, 1'b0);

    // Reset while term 3 is being accumulated.
    load_matrix(m123, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();
    check_reset_state("rst_calc");
    run_matrix("rst_calc_ident", ident, DETW'(1), 1'b0, 1'b0);

    check("exp_q_empty", MW'(exp_q.size()), MW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
